control_sequencer: RTL and testbench

- Fetch/decode/execute sequencer for the 4-bit accumulator/register datapath.
- Fetches 8-bit instructions from program ROM through a req/ack handshake and keeps a 12-bit program counter.
- Decodes each instruction and drives the datapath control strobes for exactly one cycle per executed instruction.
- Sits between the program ROM and the datapath; it is the only driver of the datapath control inputs.

---
 rtl/ctrl_pkg.sv | 38 +++
 rtl/inst_decoder.sv | 35 +++
 rtl/control_sequencer.sv | 112 +++++++++++
 tb/tb_control_sequencer.sv | 254 +++++++++++++++++++++++++
 4 files changed

// File: rtl/ctrl_pkg.sv
// Shared opcodes, FSM states and control bundle for the fetch/decode/execute sequencer.
// CTRL_HALT_ON_ILLEGAL_EN adds the HALT state.
package ctrl_pkg;

  localparam logic [7:0] OP_NOP  = 8'h00;
  localparam logic [7:0] OP_CLB  = 8'hF0;
  localparam logic [7:0] OP_CLC  = 8'hF1;
  localparam logic [3:0] OPH_LDM = 4'hD;
  localparam logic [3:0] OPH_LD  = 4'hA;
  localparam logic [3:0] OPH_STR = 4'hB;
  localparam logic [3:0] OPH_JUN = 4'h4;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FETCH,
    ST_FETCH2,
`ifdef CTRL_HALT_ON_ILLEGAL_EN
    ST_EXEC,
    ST_HALT
`else
    ST_EXEC
`endif
  } state_t;

  typedef struct packed {
    logic clear_carry;
    logic clear_accumulator;
    logic write_accumulator;
    logic acc_input_sel;
    logic write_register;
    logic reg_input_sel;
  } ctrl_t;

  function automatic logic is_two_byte(input logic [7:0] op);
    return op[7:4] == OPH_JUN;
  endfunction

endpackage

// File: rtl/inst_decoder.sv
// Combinational instruction decode: IR byte to datapath control bundle plus illegal flag.
module inst_decoder
  import ctrl_pkg::*;
(
  input  logic [7:0] ir_i,
  output ctrl_t      ctrl_o,
  output logic       illegal_o
);

  always_comb begin
    ctrl_o    = '0;
    illegal_o = 1'b0;
    case (ir_i[7:4])
      OPH_LDM: ctrl_o.write_accumulator = 1'b1;
      OPH_LD: begin
        ctrl_o.write_accumulator = 1'b1;
        ctrl_o.acc_input_sel     = 1'b1;
      end
      OPH_STR: ctrl_o.write_register = 1'b1;
      // JUN completes in FETCH2 and never reaches EXEC, so it is not flagged here.
      OPH_JUN: ;
      default: begin
        if (ir_i == OP_CLB) begin
          ctrl_o.clear_accumulator = 1'b1;
          ctrl_o.clear_carry       = 1'b1;
        end else if (ir_i == OP_CLC) begin
          ctrl_o.clear_carry = 1'b1;
        end else if (ir_i != OP_NOP) begin
          illegal_o = 1'b1;
        end
      end
    endcase
  end

endmodule

// File: rtl/control_sequencer.sv
// Fetch/decode/execute sequencer driving the 4-bit datapath strobes from ROM instructions.
// CTRL_HALT_ON_ILLEGAL_EN: an undefined opcode parks the FSM in HALT until reset.
module control_sequencer
  import ctrl_pkg::*;
#(
  parameter int unsigned     PC_W     = 12,
  parameter logic [PC_W-1:0] RESET_PC = '0
) (
  input  logic            clock,
  input  logic            reset,
  output logic            rom_req,
  output logic [PC_W-1:0] rom_addr,
  input  logic            rom_ack,
  input  logic [7:0]      rom_data,
  output logic            clear_carry,
  output logic            clear_accumulator,
  output logic            write_accumulator,
  output logic            acc_input_sel,
  output logic            write_register,
  output logic            reg_input_sel,
  output logic [3:0]      inst_operand,
  output logic            inst_retired,
  output logic            illegal_op
);

  state_t          state_q, state_d;
  logic [PC_W-1:0] pc_q, pc_d;
  logic [7:0]      ir_q, ir_d;
  ctrl_t           dec_ctrl;
  logic            dec_illegal;

  inst_decoder u_dec (
    .ir_i      (ir_q),
    .ctrl_o    (dec_ctrl),
    .illegal_o (dec_illegal)
  );

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= ST_IDLE;
      pc_q    <= RESET_PC;
      ir_q    <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      ir_q    <= ir_d;
    end
  end

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    ir_d    = ir_q;
    case (state_q)
      ST_IDLE: state_d = ST_FETCH;
      ST_FETCH: if (rom_ack) begin
        ir_d    = rom_data;
        pc_d    = pc_q + PC_W'(1);
        state_d = is_two_byte(rom_data) ? ST_FETCH2 : ST_EXEC;
      end
      ST_FETCH2: if (rom_ack) begin
        pc_d    = PC_W'({ir_q[3:0], rom_data});
        state_d = ST_FETCH;
      end
`ifdef CTRL_HALT_ON_ILLEGAL_EN
      ST_EXEC: state_d = dec_illegal ? ST_HALT : ST_FETCH;
      ST_HALT: state_d = ST_HALT;
`else
      ST_EXEC: state_d = ST_FETCH;
`endif
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    rom_req           = 1'b0;
    clear_carry       = 1'b0;
    clear_accumulator = 1'b0;
    write_accumulator = 1'b0;
    acc_input_sel     = 1'b0;
    write_register    = 1'b0;
    reg_input_sel     = 1'b0;
    inst_retired      = 1'b0;
    illegal_op        = 1'b0;
    case (state_q)
      ST_FETCH: rom_req = 1'b1;
      ST_FETCH2: begin
        rom_req      = 1'b1;
        inst_retired = rom_ack;
      end
      ST_EXEC: begin
        clear_carry       = dec_ctrl.clear_carry;
        clear_accumulator = dec_ctrl.clear_accumulator;
        write_accumulator = dec_ctrl.write_accumulator;
        acc_input_sel     = dec_ctrl.acc_input_sel;
        write_register    = dec_ctrl.write_register;
        reg_input_sel     = dec_ctrl.reg_input_sel;
        illegal_op        = dec_illegal;
`ifdef CTRL_HALT_ON_ILLEGAL_EN
        inst_retired      = !dec_illegal;
`else
        inst_retired      = 1'b1;
`endif
      end
      default: ;
    endcase
  end

  assign rom_addr     = pc_q;
  assign inst_operand = ir_q[3:0];

endmodule

// File: tb/tb_control_sequencer.sv
// Directed bench for control_sequencer: a ROM responder with configurable ack latency
// and per-scenario tasks checking strobes, fetch addresses and retire/illegal pulses.
module tb_control_sequencer;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        rom_req;
  logic [11:0] rom_addr;
  logic        rom_ack = 1'b0;
  logic [7:0]  rom_data = 8'h00;
  logic        clear_carry, clear_accumulator, write_accumulator, acc_input_sel;
  logic        write_register, reg_input_sel, inst_retired, illegal_op;
  logic [3:0]  inst_operand;

  logic [7:0]  mem [0:4095];
  int          ack_delay = 0;
  int          wait_cnt = 0;
  int          checks = 0;
  int          errors = 0;

  // {rom_req, cc, ca, wa, asel, wr, rsel, retired, illegal}
  wire [8:0] obs = {rom_req, clear_carry, clear_accumulator, write_accumulator,
                    acc_input_sel, write_register, reg_input_sel, inst_retired, illegal_op};

  localparam logic [8:0] O_IDLE   = 9'b0_000000_00;
  localparam logic [8:0] O_FETCH  = 9'b1_000000_00;
  localparam logic [8:0] O_FETCH2 = 9'b1_000000_10;
  localparam logic [8:0] O_LDM    = 9'b0_001000_10;
  localparam logic [8:0] O_STR    = 9'b0_000010_10;
  localparam logic [8:0] O_LD     = 9'b0_001100_10;
  localparam logic [8:0] O_CLC    = 9'b0_100000_10;
  localparam logic [8:0] O_CLB    = 9'b0_110000_10;
  localparam logic [8:0] O_NOP    = 9'b0_000000_10;
`ifdef CTRL_HALT_ON_ILLEGAL_EN
  localparam logic [8:0] O_ILL    = 9'b0_000000_01;
`else
  localparam logic [8:0] O_ILL    = 9'b0_000000_11;
`endif

  control_sequencer #(.PC_W(12), .RESET_PC(12'h000)) dut (
    .clock             (clock),
    .reset             (reset),
    .rom_req           (rom_req),
    .rom_addr          (rom_addr),
    .rom_ack           (rom_ack),
    .rom_data          (rom_data),
    .clear_carry       (clear_carry),
    .clear_accumulator (clear_accumulator),
    .write_accumulator (write_accumulator),
    .acc_input_sel     (acc_input_sel),
    .write_register    (write_register),
    .reg_input_sel     (reg_input_sel),
    .inst_operand      (inst_operand),
    .inst_retired      (inst_retired),
    .illegal_op        (illegal_op)
  );

  always #5 clock = ~clock;

  // ROM answers ack_delay cycles after a request appears; ack is held for one cycle.
  always @(negedge clock) begin
    if (!rom_req) begin
      rom_ack  = 1'b0;
      wait_cnt = 0;
    end else if (wait_cnt >= ack_delay) begin
      rom_ack  = 1'b1;
      rom_data = mem[rom_addr];
      wait_cnt = 0;
    end else begin
      rom_ack  = 1'b0;
      wait_cnt++;
    end
  end

  task automatic step();
    @(negedge clock);
    #1;
  endtask

  task automatic clear_mem();
    for (int i = 0; i < 4096; i++) mem[i] = 8'h00;
  endtask

  task automatic do_reset();
    @(negedge clock);
    reset = 1'b0;
    repeat (2) @(negedge clock);
    reset = 1'b1;
    #1;
  endtask

  task automatic test_reset();
    clear_mem();
    ack_delay = 0;
    reset = 1'b0;
    repeat (3) @(negedge clock);
    #1;
    checks++; if (obs !== O_IDLE) begin errors++; $display("FAIL reset_outputs got %b exp %b", obs, O_IDLE); end
    checks++; if (rom_addr !== 12'h000) begin errors++; $display("FAIL reset_addr got %h exp %h", rom_addr, 12'h000); end
    checks++; if (inst_operand !== 4'h0) begin errors++; $display("FAIL reset_operand got %h exp %h", inst_operand, 4'h0); end
    @(negedge clock);
    reset = 1'b1;
    #1;
    checks++; if (rom_req !== 1'b0) begin errors++; $display("FAIL release_req_early got %b exp %b", rom_req, 1'b0); end
    step();
    checks++; if (obs !== O_FETCH) begin errors++; $display("FAIL first_fetch got %b exp %b", obs, O_FETCH); end
  endtask

  task automatic test_fetch_sequence();
    clear_mem();
    mem[0] = 8'hD7; mem[1] = 8'hB3; mem[2] = 8'hA3;
    ack_delay = 0;
    do_reset();
    step();
    checks++; if (rom_addr !== 12'h000) begin errors++; $display("FAIL seq_addr0 got %h exp %h", rom_addr, 12'h000); end
    step();
    checks++; if (obs !== O_LDM || inst_operand !== 4'h7) begin errors++; $display("FAIL exec_ldm got %b/%h exp %b/%h", obs, inst_operand, O_LDM, 4'h7); end
    step();
    checks++; if (obs !== O_FETCH || rom_addr !== 12'h001) begin errors++; $display("FAIL seq_addr1 got %b/%h exp %b/%h", obs, rom_addr, O_FETCH, 12'h001); end
    step();
    checks++; if (obs !== O_STR || inst_operand !== 4'h3) begin errors++; $display("FAIL exec_str got %b/%h exp %b/%h", obs, inst_operand, O_STR, 4'h3); end
    step();
    checks++; if (obs !== O_FETCH || rom_addr !== 12'h002) begin errors++; $display("FAIL seq_addr2 got %b/%h exp %b/%h", obs, rom_addr, O_FETCH, 12'h002); end
    step();
    checks++; if (obs !== O_LD || inst_operand !== 4'h3) begin errors++; $display("FAIL exec_ld got %b/%h exp %b/%h", obs, inst_operand, O_LD, 4'h3); end
    step();
    checks++; if (obs !== O_FETCH || rom_addr !== 12'h003) begin errors++; $display("FAIL seq_addr3 got %b/%h exp %b/%h", obs, rom_addr, O_FETCH, 12'h003); end
  endtask

  task automatic test_slow_ack();
    int retired;
    clear_mem();
    mem[0] = 8'hD2; mem[1] = 8'hF1;
    ack_delay = 3;
    retired = 0;
    do_reset();
    for (int k = 0; k < 4; k++) begin
      step();
      if (inst_retired) retired++;
      checks++; if (obs[8:1] !== O_FETCH[8:1] || rom_addr !== 12'h000) begin errors++; $display("FAIL slow_wait0_%0d got %b/%h exp %b/%h", k, obs, rom_addr, O_FETCH, 12'h000); end
    end
    step();
    if (inst_retired) retired++;
    checks++; if (obs !== O_LDM || inst_operand !== 4'h2) begin errors++; $display("FAIL slow_ldm got %b/%h exp %b/%h", obs, inst_operand, O_LDM, 4'h2); end
    for (int k = 0; k < 4; k++) begin
      step();
      if (inst_retired) retired++;
      checks++; if (obs[8:1] !== O_FETCH[8:1] || rom_addr !== 12'h001) begin errors++; $display("FAIL slow_wait1_%0d got %b/%h exp %b/%h", k, obs, rom_addr, O_FETCH, 12'h001); end
    end
    step();
    if (inst_retired) retired++;
    checks++; if (obs !== O_CLC) begin errors++; $display("FAIL slow_clc got %b exp %b", obs, O_CLC); end
    checks++; if (retired !== 2) begin errors++; $display("FAIL slow_retired_count got %0d exp %0d", retired, 2); end
    ack_delay = 0;
  endtask

  task automatic test_jump();
    logic stray;
    clear_mem();
    mem[12'h010] = 8'h4A; mem[12'h011] = 8'h5C; mem[12'hA5C] = 8'hF0;
    ack_delay = 0;
    stray = 1'b0;
    do_reset();
    step();
    for (int k = 0; k < 32; k++) begin
      step();
      if (obs[7:2] != 6'b0 || illegal_op) stray = 1'b1;
    end
    checks++; if (stray !== 1'b0) begin errors++; $display("FAIL nop_walk_strobes got %b exp %b", stray, 1'b0); end
    checks++; if (obs[8:1] !== O_FETCH[8:1] || rom_addr !== 12'h010) begin errors++; $display("FAIL jun_first got %b/%h exp %b/%h", obs, rom_addr, O_FETCH, 12'h010); end
    step();
    checks++; if (obs !== O_FETCH2 || rom_addr !== 12'h011) begin errors++; $display("FAIL jun_second got %b/%h exp %b/%h", obs, rom_addr, O_FETCH2, 12'h011); end
    step();
    checks++; if (obs[8:1] !== O_FETCH[8:1] || rom_addr !== 12'hA5C) begin errors++; $display("FAIL jun_target got %b/%h exp %b/%h", obs, rom_addr, O_FETCH, 12'hA5C); end
    step();
    checks++; if (obs !== O_CLB) begin errors++; $display("FAIL jun_clb got %b exp %b", obs, O_CLB); end
  endtask

  task automatic test_jump_wrap();
    clear_mem();
    mem[12'h000] = 8'h4F; mem[12'h001] = 8'hFF; mem[12'hFFF] = 8'h41;
    ack_delay = 0;
    do_reset();
    step();
    step();
    step();
    checks++; if (rom_addr !== 12'hFFF) begin errors++; $display("FAIL wrap_at_fff got %h exp %h", rom_addr, 12'hFFF); end
    step();
    checks++; if (obs !== O_FETCH2 || rom_addr !== 12'h000) begin errors++; $display("FAIL wrap_second_byte got %b/%h exp %b/%h", obs, rom_addr, O_FETCH2, 12'h000); end
    step();
    checks++; if (rom_addr !== 12'h14F) begin errors++; $display("FAIL wrap_target got %h exp %h", rom_addr, 12'h14F); end
  endtask

  task automatic test_illegal();
    clear_mem();
    mem[0] = 8'h77;
    ack_delay = 0;
    do_reset();
    step();
    step();
    checks++; if (obs !== O_ILL || inst_operand !== 4'h7) begin errors++; $display("FAIL illegal_exec got %b/%h exp %b/%h", obs, inst_operand, O_ILL, 4'h7); end
`ifdef CTRL_HALT_ON_ILLEGAL_EN
    for (int k = 0; k < 5; k++) begin
      step();
      checks++; if (obs !== O_IDLE) begin errors++; $display("FAIL halt_hold_%0d got %b exp %b", k, obs, O_IDLE); end
    end
`else
    step();
    checks++; if (obs[8:1] !== O_FETCH[8:1] || rom_addr !== 12'h001) begin errors++; $display("FAIL illegal_next got %b/%h exp %b/%h", obs, rom_addr, O_FETCH, 12'h001); end
    step();
    checks++; if (obs !== O_NOP) begin errors++; $display("FAIL illegal_then_nop got %b exp %b", obs, O_NOP); end
`endif
  endtask

  task automatic test_async_reset();
    clear_mem();
    mem[0] = 8'hD7;
    ack_delay = 0;
    do_reset();
    step();
    step();
    checks++; if (obs !== O_LDM) begin errors++; $display("FAIL areset_pre_exec got %b exp %b", obs, O_LDM); end
    reset = 1'b0;
    #1;
    checks++; if (obs !== O_IDLE || rom_addr !== 12'h000) begin errors++; $display("FAIL areset_exec_drop got %b/%h exp %b/%h", obs, rom_addr, O_IDLE, 12'h000); end
    ack_delay = 5;
    do_reset();
    step();
    step();
    checks++; if (obs[8:1] !== O_FETCH[8:1]) begin errors++; $display("FAIL areset_pre_fetch got %b exp %b", obs, O_FETCH); end
    reset = 1'b0;
    #1;
    checks++; if (obs !== O_IDLE) begin errors++; $display("FAIL areset_fetch_drop got %b exp %b", obs, O_IDLE); end
    ack_delay = 0;
    do_reset();
    step();
    checks++; if (obs !== O_FETCH || rom_addr !== 12'h000) begin errors++; $display("FAIL areset_restart got %b/%h exp %b/%h", obs, rom_addr, O_FETCH, 12'h000); end
    step();
    checks++; if (obs !== O_LDM) begin errors++; $display("FAIL areset_restart_exec got %b exp %b", obs, O_LDM); end
  endtask

  initial begin
    test_reset();
    test_fetch_sequence();
    test_slow_ack();
    test_jump();
    test_jump_wrap();
    test_illegal();
    test_async_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
